// File: rtl/div_iter_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_iter_pkg;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic int iters_f(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quo_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // rem_i < divisor_i, so the trial difference fits WIDTH+1 bits and its MSB is the borrow.
  assign shifted_s = {rem_i, bit_i};
  assign trial_s   = shifted_s - {1'b0, divisor_i};
  assign quo_o     = ~trial_s[WIDTH];
  assign rem_o     = quo_o ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned restoring divider, BITS_PER_CYCLE quotient bits per cycle.
// result = {remainder, quotient}, held until the next completed operation.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               start,
  input  logic               flag_unsigned,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int ITERS = iters_f(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(ITERS + 1);

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, dvd_q, dvs_q;
  logic               sign_quo_q, sign_rem_q;
  logic               busy_q, done_q, dbz_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   abs1_d, abs2_d, rem_d, dvd_d, quo_fix_d, rem_fix_d, rem_src_s;
  logic               neg1_s, neg2_s, dvs_zero_s;

  // Step chain: dvd_q shifts dividend bits out of the MSB and quotient bits into the LSB.
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic [WIDTH-1:0] rem_in_s, dvd_in_s, rem_out_s, dvd_out_s;
    logic             q_bit_s;
    if (k == 0) begin : g_first
      assign rem_in_s = rem_q;
      assign dvd_in_s = dvd_q;
    end else begin : g_next
      assign rem_in_s = g_step[k-1].rem_out_s;
      assign dvd_in_s = g_step[k-1].dvd_out_s;
    end
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_in_s),
      .bit_i     (dvd_in_s[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (rem_out_s),
      .quo_o     (q_bit_s)
    );
    assign dvd_out_s = {dvd_in_s[WIDTH-2:0], q_bit_s};
  end

  assign rem_d = g_step[BITS_PER_CYCLE-1].rem_out_s;
  assign dvd_d = g_step[BITS_PER_CYCLE-1].dvd_out_s;

  // Operand magnitudes at accept and sign-corrected results for the FIX cycle.
  always_comb begin
    neg1_s     = ~flag_unsigned & operand1[WIDTH-1];
    neg2_s     = ~flag_unsigned & operand2[WIDTH-1];
    abs1_d     = neg1_s ? -operand1 : operand1;
    abs2_d     = neg2_s ? -operand2 : operand2;
    dvs_zero_s = (dvs_q == {WIDTH{1'b0}});
    rem_src_s  = dvs_zero_s ? dvd_q : rem_q;
    quo_fix_d  = dvs_zero_s ? {WIDTH{1'b1}} : (sign_quo_q ? -dvd_q : dvd_q);
    rem_fix_d  = sign_rem_q ? -rem_src_s : rem_src_s;
  end

  // Control FSM with registered handshake outputs; done trails the DONE state by one cycle.
  always_ff @(posedge clock) begin
    if (reset == RST_ENABLE) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      dvd_q      <= {WIDTH{1'b0}};
      dvs_q      <= {WIDTH{1'b0}};
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      result_q   <= {(2*WIDTH){1'b0}};
    end else if (flush) begin
      state_q <= DIV_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == DIV_DONE);
      case (state_q)
        DIV_IDLE: begin
          if (start && !busy_q) begin
            dvd_q      <= abs1_d;
            dvs_q      <= abs2_d;
            rem_q      <= {WIDTH{1'b0}};
            sign_quo_q <= neg1_s ^ neg2_s;
            sign_rem_q <= neg1_s;
            cnt_q      <= CNT_W'(ITERS);
            busy_q     <= 1'b1;
            state_q    <= (abs2_d == {WIDTH{1'b0}}) ? DIV_FIX : DIV_CALC;
          end else begin
            busy_q <= 1'b0;
          end
        end
        DIV_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DIV_FIX;
          end else begin
            state_q <= DIV_CALC;
          end
        end
        DIV_FIX: begin
          result_q <= {rem_fix_d, quo_fix_d};
          dbz_q    <= dvs_zero_s;
          state_q  <= DIV_DONE;
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: BPC=1, 2 and 4 instances share stimulus and are checked side by side.
module tb_div_iter;

  typedef struct {
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        pulse;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, flush, start, flag_unsigned;
  logic [31:0] operand1, operand2;
  logic [2:0]  busy_v, done_v, dbz_v;
  logic [63:0] res_v [3];
  logic [63:0] prev_res [3];
  int          iters_of [3] = '{32, 16, 8};
  int          bpc_of [3]   = '{1, 2, 4};
  int          total = 0;
  int          bad = 0;
  vec_t        vecs [12];

  always #5 clock = ~clock;

  div_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clock(clock), .reset(reset), .flush(flush), .start(start), .flag_unsigned(flag_unsigned),
    .operand1(operand1), .operand2(operand2), .busy(busy_v[0]), .done(done_v[0]),
    .result(res_v[0]), .div_by_zero(dbz_v[0]));
  div_iter #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_dut2 (
    .clock(clock), .reset(reset), .flush(flush), .start(start), .flag_unsigned(flag_unsigned),
    .operand1(operand1), .operand2(operand2), .busy(busy_v[1]), .done(done_v[1]),
    .result(res_v[1]), .div_by_zero(dbz_v[1]));
  div_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clock(clock), .reset(reset), .flush(flush), .start(start), .flag_unsigned(flag_unsigned),
    .operand1(operand1), .operand2(operand2), .busy(busy_v[2]), .done(done_v[2]),
    .result(res_v[2]), .div_by_zero(dbz_v[2]));

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s bpc=%0d got=%h want=%h", nm, bpc_of[inst], act, exp);
    end
  endtask

  // Applies one operation to all instances and checks latency, pulse count, result and flag.
  task automatic run_op(input logic uns, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input logic pulse);
    int          first [3];
    int          cnt [3];
    int          lat [3];
    logic [63:0] got [3];
    logic        gdbz [3];
    for (int i = 0; i < 3; i++) begin
      first[i] = -1;
      cnt[i]   = 0;
      got[i]   = 64'd0;
      gdbz[i]  = 1'b0;
      lat[i]   = (b == 32'd0) ? 2 : iters_of[i] + 2;
    end
    flag_unsigned = uns;
    operand1 = a;
    operand2 = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
    for (int i = 0; i < 3; i++) begin
      chk("busy_after_accept", i, 64'(busy_v[i]), 64'd1);
      chk("result_held_at_accept", i, res_v[i], prev_res[i]);
    end
    for (int e = 1; e <= 60; e++) begin
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          cnt[i]++;
          if (first[i] < 0) begin
            first[i] = e;
            got[i]   = res_v[i];
            gdbz[i]  = dbz_v[i];
          end
        end
        if (e == lat[i]) chk("busy_in_done_cycle", i, 64'(busy_v[i]), 64'd1);
        if (e == lat[i] + 1) chk("busy_after_done", i, 64'(busy_v[i]), 64'd0);
      end
      if (pulse && e == 3) begin
        start = 1'b1;
        operand1 = 32'd999;
        operand2 = 32'd10;
      end else begin
        start = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("latency", i, 64'(first[i]), 64'(lat[i]));
      chk("done_pulses", i, 64'(cnt[i]), 64'd1);
      chk("result", i, got[i], {er, eq});
      chk("div_by_zero", i, 64'(gdbz[i]), 64'(edbz));
      prev_res[i] = {er, eq};
    end
  endtask

  initial begin
    int nd;
    int first;
    vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF,   32'd3,          32'h55555555,   32'd0,          1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF0,   1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'hDEADBEEF,   32'd1,          32'hDEADBEEF,   32'd0,          1'b0, 1'b0};

    reset = 1'b1;
    flush = 1'b0;
    start = 1'b0;
    flag_unsigned = 1'b0;
    operand1 = 32'd0;
    operand2 = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", i, 64'(busy_v[i]), 64'd0);
      chk("reset_done", i, 64'(done_v[i]), 64'd0);
      chk("reset_result", i, res_v[i], 64'd0);
      chk("reset_dbz", i, 64'(dbz_v[i]), 64'd0);
      prev_res[i] = 64'd0;
    end
    reset = 1'b0;
    @(posedge clock); #1;

    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].uns, vecs[v].a, vecs[v].b, vecs[v].q, vecs[v].r, vecs[v].dbz, vecs[v].pulse);
    end

    // Flush mid-operation with a simultaneous start, then a fresh start on the next cycle.
    flag_unsigned = 1'b1;
    operand1 = 32'd100;
    operand2 = 32'd7;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    nd = 0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clock); #1;
      if (|done_v) nd++;
    end
    flush = 1'b1;
    start = 1'b1;
    operand1 = 32'd5;
    operand2 = 32'd5;
    @(posedge clock); #1;
    flush = 1'b0;
    start = 1'b0;
    chk("flush_no_done", 0, 64'(nd), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_busy_low", i, 64'(busy_v[i]), 64'd0);
      chk("flush_result_kept", i, res_v[i], prev_res[i]);
    end
    run_op(1'b1, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 1'b0);

    // Back-to-back on the BPC=1 instance: start in the done cycle is ignored, next cycle is accepted.
    flag_unsigned = 1'b1;
    operand1 = 32'd200;
    operand2 = 32'd7;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    first = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clock); #1;
      if (done_v[0]) begin
        first = e;
        break;
      end
    end
    chk("b2b_first_latency", 0, 64'(first), 64'd34);
    chk("b2b_first_result", 0, res_v[0], {32'd4, 32'd28});
    start = 1'b1;
    operand1 = 32'd77;
    operand2 = 32'd7;
    @(posedge clock); #1;
    chk("start_in_done_ignored", 0, 64'(busy_v[0]), 64'd0);
    operand1 = 32'd50;
    operand2 = 32'd6;
    @(posedge clock); #1;
    start = 1'b0;
    chk("start_after_done_accepted", 0, 64'(busy_v[0]), 64'd1);
    first = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clock); #1;
      if (done_v[0]) begin
        first = e;
        break;
      end
    end
    chk("b2b_second_latency", 0, 64'(first), 64'd34);
    chk("b2b_second_result", 0, res_v[0], {32'd2, 32'd8});
    repeat (60) @(posedge clock);
    #1;

    // Reset in the middle of an operation returns every output to its reset value.
    operand1 = 32'd100;
    operand2 = 32'd7;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midreset_busy", i, 64'(busy_v[i]), 64'd0);
      chk("midreset_result", i, res_v[i], 64'd0);
      chk("midreset_dbz", i, 64'(dbz_v[i]), 64'd0);
    end
    nd = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (|done_v) nd++;
    end
    chk("midreset_no_done", 0, 64'(nd), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
